// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: handshaked inter-stage register for the five-stage core.
// A main entry drives the outputs and a skid entry absorbs the one beat that
// may arrive while downstream stalls. This lets in_ready come straight from
// the state register, so there is no combinational path from out_ready to
// in_ready. Flush inserts a bubble. out_ctrl is gated to zero whenever no beat
// is held, so a bubble never carries reg_write or mem_write downstream.
module pipe_skid_stage #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 3,
  parameter int SEL_W  = 3,
  parameter int CTRL_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [CTRL_W-1:0]        in_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [1:0]               occupancy
);

  localparam int PW = NUM_CH * DATA_W;

  // The encoding equals the occupancy, so occupancy is the state register itself.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, load_skid;
  logic vld_p1;

  // Stage p1 storage: main entry (visible) and skid entry (overflow)
  logic [PW-1:0]     main_data_p1, skid_data_p1;
  logic [SEL_W-1:0]  main_sel_p1,  skid_sel_p1;
  logic [CTRL_W-1:0] main_ctrl_p1, skid_ctrl_p1;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register; reset takes priority over every other input
  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  // Next-state and load selection; flush outranks every handshake
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_fire) begin
            state_nxt    = S_ONE;
            load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (in_fire && !out_fire) begin
            state_nxt = S_FULL;
            load_skid = 1'b1;
          end else if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (out_fire) begin
            state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            state_nxt      = S_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // Payload registers; cleared on reset, left untouched by flush
  always_ff @(posedge clk) begin
    if (rst) begin
      main_data_p1 <= '0;
      main_sel_p1  <= '0;
      main_ctrl_p1 <= '0;
      skid_data_p1 <= '0;
      skid_sel_p1  <= '0;
      skid_ctrl_p1 <= '0;
    end else begin
      if (load_main_in) begin
        main_data_p1 <= in_data;
        main_sel_p1  <= in_sel;
        main_ctrl_p1 <= in_ctrl;
      end else if (load_main_skid) begin
        main_data_p1 <= skid_data_p1;
        main_sel_p1  <= skid_sel_p1;
        main_ctrl_p1 <= skid_ctrl_p1;
      end
      if (load_skid) begin
        skid_data_p1 <= in_data;
        skid_sel_p1  <= in_sel;
        skid_ctrl_p1 <= in_ctrl;
      end
    end
  end

  // Outputs decoded from the state register only; ctrl is gated on bubbles
  always_comb begin
    vld_p1    = (state != S_EMPTY);
    out_valid = vld_p1;
    in_ready  = (state != S_FULL);
    occupancy = state;
    out_data  = main_data_p1;
    out_sel   = main_sel_p1;
    out_ctrl  = vld_p1 ? main_ctrl_p1 : '0;
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a default instance and a wide variant share the
// same handshake signals. A queue-of-beats model (capacity two) predicts both.
module tb_pipe_skid_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, in_valid, out_ready;
  logic [47:0] in_data1;  logic [2:0] in_sel1;  logic [4:0] in_ctrl1;
  logic [63:0] in_data2;  logic [3:0] in_sel2;  logic [7:0] in_ctrl2;

  logic        in_ready1, out_valid1, in_ready2, out_valid2;
  logic [47:0] out_data1; logic [2:0] out_sel1; logic [4:0] out_ctrl1;
  logic [63:0] out_data2; logic [3:0] out_sel2; logic [7:0] out_ctrl2;
  logic [1:0]  occ1, occ2;

  pipe_skid_stage dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data1), .in_sel(in_sel1), .in_ctrl(in_ctrl1),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_sel(out_sel1), .out_ctrl(out_ctrl1),
    .occupancy(occ1)
  );

  pipe_skid_stage #(.DATA_W(32), .NUM_CH(2), .SEL_W(4), .CTRL_W(8)) dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data2), .in_sel(in_sel2), .in_ctrl(in_ctrl2),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_sel(out_sel2), .out_ctrl(out_ctrl2),
    .occupancy(occ2)
  );

  typedef struct packed {
    logic [47:0] d1; logic [2:0] s1; logic [4:0] c1;
    logic [63:0] d2; logic [3:0] s2; logic [7:0] c2;
  } beat_t;

  beat_t q[$];
  beat_t hold;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a FIFO of at most two beats. The visible payload is the head, or
  // the last head once the FIFO drains. Inputs are sampled at the rising edge.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      hold = '0;
    end else begin
      bit of, inf;
      of  = (q.size() > 0) && out_ready;
      inf = in_valid && (q.size() < 2);
      if (of) void'(q.pop_front());
      if (flush) q.delete();
      else if (inf) q.push_back({in_data1, in_sel1, in_ctrl1, in_data2, in_sel2, in_ctrl2});
      if (q.size() > 0) hold = q[0];
    end
  end

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin
    bit v;
    v = (q.size() > 0);
    chk("d1_valid", out_valid1, v);
    chk("d1_ready", in_ready1, q.size() < 2);
    chk("d1_occ",   occ1, q.size());
    chk("d1_data",  out_data1, hold.d1);
    chk("d1_sel",   out_sel1, hold.s1);
    chk("d1_ctrl",  out_ctrl1, v ? hold.c1 : 5'd0);
    chk("d2_valid", out_valid2, v);
    chk("d2_ready", in_ready2, q.size() < 2);
    chk("d2_occ",   occ2, q.size());
    chk("d2_data",  out_data2, hold.d2);
    chk("d2_sel",   out_sel2, hold.s2);
    chk("d2_ctrl",  out_ctrl2, v ? hold.c2 : 8'd0);
  end

  task automatic drive(input logic v, input logic [15:0] ch0, input logic [2:0] s);
    in_valid = v;
    in_data1 = {32'h0, ch0};
    in_sel1  = s;
    in_ctrl1 = 5'b10001;
    in_data2 = {32'hDEADBEEF, 16'h0, ch0};
    in_sel2  = 4'hA;
    in_ctrl2 = 8'h81;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 3'd7);

    // Reset held two cycles with in_valid high: nothing captured
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid1, 1'b0);
    chk("rst_occ",   occ1, 2'd0);
    chk("rst_ready", in_ready1, 1'b1);
    chk("rst_ctrl",  out_ctrl1, 5'd0);
    chk("rst_data",  out_data1, 48'd0);
    rst = 1'b0;

    // Pass-through: one-cycle latency, stays in ONE with both fires
    out_ready = 1'b1;
    drive(1'b1, 16'h1234, 3'd1);
    @(negedge clk);
    chk("pt_a_data", out_data1, 48'h1234);
    chk("pt_a_ctrl", out_ctrl1, 5'b10001);
    chk("pt_a_d2",   out_data2, 64'hDEADBEEF_00001234);
    chk("pt_a_sel2", out_sel2, 4'hA);
    drive(1'b1, 16'hBEEF, 3'd2);
    @(negedge clk);
    chk("pt_b_data", out_data1, 48'hBEEF);
    chk("pt_b_occ",  occ1, 2'd1);
    chk("pt_b_rdy",  in_ready1, 1'b1);
    drive(1'b1, 16'h0F0F, 3'd3);
    @(negedge clk);
    chk("pt_c_data", out_data1, 48'h0F0F);
    chk("pt_c_sel",  out_sel1, 3'd3);
    drive(1'b0, 16'h0, 3'd0);
    @(negedge clk);
    chk("pt_empty",  occ1, 2'd0);
    chk("pt_hold",   out_data1, 48'h0F0F);
    chk("pt_ctrl0",  out_ctrl1, 5'd0);

    // Backpressure: fill both entries, C stalls upstream, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 3'd1);
    @(negedge clk);
    drive(1'b1, 16'h2222, 3'd2);
    @(negedge clk);
    chk("bp_occ2",  occ1, 2'd2);
    chk("bp_rdy0",  in_ready1, 1'b0);
    drive(1'b1, 16'h3333, 3'd3);
    @(negedge clk);
    chk("bp_still", occ1, 2'd2);
    chk("bp_a",     out_data1, 48'h1111);
    chk("bp_a_d2",  out_data2, 64'hDEADBEEF_00001111);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_b",     out_data1, 48'h2222);
    chk("bp_b_occ", occ1, 2'd1);
    @(negedge clk);
    chk("bp_c",     out_data1, 48'h3333);
    chk("bp_c_vld", out_valid1, 1'b1);
    drive(1'b0, 16'h0, 3'd0);
    @(negedge clk);
    chk("bp_done",  occ1, 2'd0);

    // Flush while FULL with an input beat offered
    out_ready = 1'b0;
    drive(1'b1, 16'h4444, 3'd4);
    @(negedge clk);
    drive(1'b1, 16'h5555, 3'd5);
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 16'h6666, 3'd6);
    @(negedge clk);
    flush = 1'b0;
    chk("fl_occ",   occ1, 2'd0);
    chk("fl_vld",   out_valid1, 1'b0);
    chk("fl_ctrl",  out_ctrl1, 5'd0);
    chk("fl_rdy",   in_ready1, 1'b1);
    chk("fl_hold",  out_data1, 48'h4444);
    drive(1'b0, 16'h0, 3'd0);
    out_ready = 1'b1;
    @(negedge clk);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data1  = 48'({$urandom(), $urandom()});
      in_sel1   = 3'($urandom());
      in_ctrl1  = 5'($urandom());
      in_data2  = {$urandom(), $urandom()};
      in_sel2   = 4'($urandom());
      in_ctrl2  = 8'($urandom());
    end
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
